// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    // All-zero word injected into IF/ID on bubbles and flushes.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Sequential PC step in bytes.
    localparam int PC_INC = 4;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: owns PC, issues imem fetches, loads the IF/ID register.
// Latency: 1 cycle from imem_ack to IF/ID valid; 1 bubble per memory wait state.
// Backpressure: stall freezes PC and IF/ID; an ack taken under stall parks in HOLD.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_address,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus4,
    output logic               ifid_valid
);

    fetch_state_t       state, state_n;
    logic [ADDR_W-1:0]  pc_n;
    logic [INSTR_W-1:0] hold_reg, hold_n;
    logic [ADDR_W-1:0]  redir_reg, redir_n;
    logic [INSTR_W-1:0] instr_n;
    logic [ADDR_W-1:0]  pc4_n;
    logic               valid_n;

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_plus4;

    assign redirect = jump | branch_taken;
    assign target   = jump ? jump_address : branch_address;
    assign pc_plus4 = pc + ADDR_W'(PC_INC);

    // Memory request depends on registered state only, never on ack/stall/redirect.
    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = pc;

    // State, PC and IF/ID registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            hold_reg      <= '0;
            redir_reg     <= '0;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            hold_reg      <= hold_n;
            redir_reg     <= redir_n;
            ifid_instr    <= instr_n;
            ifid_pc_plus4 <= pc4_n;
            ifid_valid    <= valid_n;
        end
    end

    // Next-state and IF/ID update; redirect beats stall, stall beats bubble.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        hold_n  = hold_reg;
        redir_n = redir_reg;
        instr_n = ifid_instr;
        pc4_n   = ifid_pc_plus4;
        valid_n = ifid_valid;

        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redirect) begin
                    valid_n = 1'b0;
                    instr_n = INSTR_W'(NOP);
                end
            end

            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Fetched word is on the wrong path: drop it and refetch.
                        pc_n    = target;
                        valid_n = 1'b0;
                        instr_n = INSTR_W'(NOP);
                    end else if (stall) begin
                        // Park the word; IF/ID and PC stay frozen until release.
                        hold_n  = imem_rdata;
                        state_n = HOLD;
                    end else begin
                        instr_n = imem_rdata;
                        pc4_n   = pc_plus4;
                        valid_n = 1'b1;
                        pc_n    = pc_plus4;
                    end
                end else begin
                    if (redirect) begin
                        // Fetch still in flight: remember target, drain stale ack first.
                        redir_n = target;
                        valid_n = 1'b0;
                        instr_n = INSTR_W'(NOP);
                        state_n = DISCARD;
                    end else if (!stall) begin
                        valid_n = 1'b0;
                        instr_n = INSTR_W'(NOP);
                    end
                end
            end

            DISCARD: begin
                if (redirect) begin
                    redir_n = target;
                    valid_n = 1'b0;
                    instr_n = INSTR_W'(NOP);
                end else if (!stall) begin
                    valid_n = 1'b0;
                    instr_n = INSTR_W'(NOP);
                end
                if (imem_ack) begin
                    // Stale word is dropped; a same-cycle redirect wins over the saved one.
                    pc_n    = redirect ? target : redir_reg;
                    state_n = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_n    = target;
                    valid_n = 1'b0;
                    instr_n = INSTR_W'(NOP);
                    state_n = FETCH;
                end else if (!stall) begin
                    instr_n = hold_reg;
                    pc4_n   = pc_plus4;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4;
                    state_n = FETCH;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl with a wait-state memory model.
// Latency: expectations pushed on ack, popped one cycle later at IF/ID.
// Backpressure: stall and redirects driven from directed phases.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_address;
    logic        jump;
    logic [9:0]  jump_address;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [9:0]  pc;
    logic [31:0] ifid_instr;
    logic [9:0]  ifid_pc_plus4;
    logic        ifid_valid;

    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  pc4;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   waits = 0;
    int   wcnt  = 0;
    logic sb_en = 1'b0;
    logic prev_wait = 1'b0;
    logic [9:0] prev_addr = '0;

    if_fetch_ctrl #(.ADDR_W(10), .INSTR_W(32), .RESET_PC(10'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = address, ack after 'waits' wait cycles.
    assign imem_ack   = imem_req && (wcnt >= waits);
    assign imem_rdata = {22'd0, imem_addr};

    always @(posedge clk or negedge reset) begin
        if (!reset)                   wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                          wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: pop last cycle's expectation, then push this cycle's ack.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_wait = 1'b0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ifid_valid", {63'd0, ifid_valid}, 64'd1);
                chk("ifid_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
                chk("ifid_pc_plus4", {54'd0, ifid_pc_plus4}, {54'd0, e.pc4});
            end else if (sb_en) begin
                chk("bubble_valid", {63'd0, ifid_valid}, 64'd0);
            end
            if (sb_en && prev_wait && imem_req)
                chk("addr_stable", {54'd0, imem_addr}, {54'd0, prev_addr});
            if (sb_en && imem_ack && !stall && !jump && !branch_taken) begin
                e.instr = {22'd0, imem_addr};
                e.pc4   = imem_addr + 10'd4;
                exp_q.push_back(e);
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        tick;
        sb_en = 1'b0;
        reset = 1'b0;
        tick;
        tick;
        exp_q.delete();
        reset = 1'b1;
        sb_en = 1'b1;
    endtask

    // Advance until a fetch to address a has just been issued (no wait elapsed).
    task automatic wait_fetch_start(input logic [9:0] a);
        bit found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick;
            if (imem_req && wcnt == 0 && imem_addr == a) found = 1'b1;
        end
        if (!found) chk("fetch_start_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_address = '0;
        jump = 1'b0;
        jump_address = '0;
        waits = 0;
        #3 reset = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", {54'd0, pc}, 64'd0);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, ifid_valid}, 64'd0);
        chk("rst_instr", {32'd0, ifid_instr}, 64'd0);
        chk("rst_pc4", {54'd0, ifid_pc_plus4}, 64'd0);

        // Zero-wait stream: pc 0,4,8 and IF/ID one cycle later
        tick;
        reset = 1'b1;
        sb_en = 1'b1;
        @(negedge clk);
        chk("idle_req", {63'd0, imem_req}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("seq_pc", {54'd0, pc}, 64'(i * 4));
            chk("seq_req", {63'd0, imem_req}, 64'd1);
        end
        repeat (3) tick;

        // Two wait states: valid pattern 1,0,0
        waits = 2;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (imem_ack) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("wait_pattern", {63'd0, ifid_valid}, (k % 3 == 0) ? 64'd1 : 64'd0);
        end

        // Branch during pending fetch at 0x008
        do_reset;
        wait_fetch_start(10'h008);
        branch_taken = 1'b1;
        branch_address = 10'h100;
        sb_en = 1'b0;
        tick;
        branch_taken = 1'b0;
        @(negedge clk);
        chk("disc_req", {63'd0, imem_req}, 64'd1);
        chk("disc_addr", {54'd0, imem_addr}, 64'h008);
        chk("disc_valid", {63'd0, ifid_valid}, 64'd0);
        tick;
        @(negedge clk);
        chk("disc_ack_addr", {54'd0, imem_addr}, 64'h008);
        chk("disc_ack", {63'd0, imem_ack}, 64'd1);
        chk("disc_ack_valid", {63'd0, ifid_valid}, 64'd0);
        tick;
        @(negedge clk);
        chk("redir_addr", {54'd0, imem_addr}, 64'h100);
        chk("redir_valid", {63'd0, ifid_valid}, 64'd0);
        tick;
        sb_en = 1'b1;
        repeat (6) tick;

        // Jump beats branch in the same cycle
        waits = 0;
        repeat (3) tick;
        jump = 1'b1;
        jump_address = 10'h200;
        branch_taken = 1'b1;
        branch_address = 10'h100;
        sb_en = 1'b0;
        tick;
        jump = 1'b0;
        branch_taken = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        chk("jmp_pc", {54'd0, pc}, 64'h200);
        chk("jmp_valid", {63'd0, ifid_valid}, 64'd0);
        repeat (2) tick;

        // Stall 3 cycles on ack at pc=0x010
        jump = 1'b1;
        jump_address = 10'h00C;
        sb_en = 1'b0;
        tick;
        jump = 1'b0;
        sb_en = 1'b1;
        tick;
        stall = 1'b1;
        sb_en = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick;
            @(negedge clk);
            chk("hold_req", {63'd0, imem_req}, 64'd0);
            chk("hold_instr", {32'd0, ifid_instr}, 64'h00C);
            chk("hold_valid", {63'd0, ifid_valid}, 64'd1);
            chk("hold_pc", {54'd0, pc}, 64'h010);
        end
        tick;
        stall = 1'b0;
        @(negedge clk);
        chk("hold_rel_req", {63'd0, imem_req}, 64'd0);
        tick;
        exp_q.push_back('{instr: 32'h010, pc4: 10'h014});
        sb_en = 1'b1;
        @(negedge clk);
        chk("rel_pc", {54'd0, pc}, 64'h014);
        repeat (2) tick;

        // PC wrap at 0x3FC
        jump = 1'b1;
        jump_address = 10'h3FC;
        sb_en = 1'b0;
        tick;
        jump = 1'b0;
        sb_en = 1'b1;
        @(negedge clk);
        chk("wrap_pc_pre", {54'd0, pc}, 64'h3FC);
        tick;
        @(negedge clk);
        chk("wrap_pc", {54'd0, pc}, 64'h000);
        chk("wrap_pc4", {54'd0, ifid_pc_plus4}, 64'h000);
        chk("wrap_instr", {32'd0, ifid_instr}, 64'h3FC);
        repeat (2) tick;

        // Reset dropped mid-DISCARD
        waits = 2;
        do_reset;
        wait_fetch_start(10'h004);
        branch_taken = 1'b1;
        branch_address = 10'h100;
        sb_en = 1'b0;
        tick;
        branch_taken = 1'b0;
        @(negedge clk);
        chk("mid_disc_req", {63'd0, imem_req}, 64'd1);
        chk("mid_disc_addr", {54'd0, imem_addr}, 64'h004);
        tick;
        reset = 1'b0;
        #1;
        chk("arst_pc", {54'd0, pc}, 64'd0);
        chk("arst_req", {63'd0, imem_req}, 64'd0);
        chk("arst_valid", {63'd0, ifid_valid}, 64'd0);
        chk("arst_instr", {32'd0, ifid_instr}, 64'd0);
        chk("arst_pc4", {54'd0, ifid_pc_plus4}, 64'd0);
        exp_q.delete();
        tick;
        tick;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        chk("post_rst_req1", {63'd0, imem_req}, 64'd1);
        chk("post_rst_addr", {54'd0, imem_addr}, 64'h000);
        repeat (2) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Sequencing controller for the instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter and next-PC selection (sequential, branch, jump), talks to a variable-latency instruction memory over a req/ack handshake, and drives the IF/ID pipeline register. It applies load-use stalls from the hazard unit and flushes on taken branch or jump. It also discards in-flight fetches made stale by a redirect.

## Interface
Parameters:
- ADDR_W, 10, PC / byte-address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit hold: freeze PC and IF/ID contents
- branch_taken  in  1  redirect to branch_address
- branch_address  in  ADDR_W  branch target
- jump  in  1  redirect to jump_address; priority over branch_taken
- jump_address  in  ADDR_W  jump target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; stable while imem_req high and no ack
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle; may be combinational from imem_req
- imem_rdata  in  INSTR_W  fetched instruction
- pc  out  ADDR_W  current fetch PC
- ifid_instr  out  INSTR_W  IF/ID instruction; NOP (all zero) when invalid
- ifid_pc_plus4  out  ADDR_W  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction

## Operation
- Reset values: pc=RESET_PC, state IDLE, imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, hold and redirect registers cleared.
- Redirect = jump | branch_taken. Target = jump ? jump_address : branch_address.
- Redirect has priority over stall. On any redirect, IF/ID is flushed: ifid_valid←0, ifid_instr←0.
- PC+4 is modulo 2^ADDR_W; 0x3FC wraps to 0x000. Targets are used unmodified.
- States:
  - IDLE: imem_req=0. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - ack & redirect: data discarded; pc←target; stay in FETCH.
    - ack & stall: hold_reg←imem_rdata; go to HOLD; pc and IF/ID unchanged.
    - ack, neither: IF/ID←{imem_rdata, pc+4}; valid←1; pc←pc+4.
    - no ack & redirect: redir_reg←target; flush; go to DISCARD.
    - no ack & stall: IF/ID held.
    - no ack, neither: bubble, valid←0.
  - DISCARD: imem_req=1, imem_addr=old pc, held until ack. A new redirect overwrites redir_reg and flushes. Without redirect, stall holds IF/ID, else bubble.
    - ack: data discarded; pc←redir_reg (or the same-cycle target if a redirect is also present); go to FETCH.
  - HOLD: imem_req=0.
    - redirect: discard hold_reg; pc←target; flush; go to FETCH.
    - stall still high: remain in HOLD.
    - stall low: IF/ID←{hold_reg, pc+4}; valid←1; pc←pc+4; go to FETCH.
- Reset asserted mid-fetch: everything returns to reset values immediately. The outstanding memory transaction is abandoned.

## Timing
- First imem_req is 1 cycle after reset release. The first valid IF/ID is the edge after the first ack.
- With imem_ack tied to 1, throughput is 1 instruction/cycle and fetch→IF/ID latency is 1 cycle.
- An N-wait-state memory costs N bubbles per instruction.
- Redirect penalty: 1 bubble when it coincides with an ack. Otherwise it adds the remaining wait of the stale fetch.
- imem_req and imem_addr are registered-state functions only (no combinational path from imem_ack, stall or redirect).

## Structure
- Shared package if_pkg holds:
  - the state enum (IDLE, FETCH, DISCARD, HOLD);
  - the NOP constant 32'h0000_0000;
  - the PC increment constant 4.
- The PC+4 adder is inline; do not instantiate the ALU for it.
- No sub-module is needed; a single module of about 200 lines.

## Test plan
- Reset release, imem_ack tied high, memory word = address: pc steps 0,4,8; ifid_instr = 0,4,8 one cycle later; valid stays high.
- 2-wait-state memory: ack every third cycle; ifid_valid pattern 1,0,0 repeating; imem_addr stable across wait cycles.
- branch_taken with branch_address=0x100 during a pending fetch at 0x008: DISCARD until ack, stale word dropped, next imem_addr=0x100, valid low throughout.
- jump=1 and branch_taken=1 in the same cycle (jump_address=0x200, branch_address=0x100): pc becomes 0x200.
- stall high for 3 cycles on an ack at pc=0x010: HOLD with imem_req=0 and IF/ID frozen. On release, IF/ID shows the 0x010 word and pc becomes 0x014.
- pc=0x3FC sequential fetch: pc wraps to 0x000 and ifid_pc_plus4=0x000. Separately, reset dropped mid-DISCARD: all outputs at reset values within the same cycle.
